// File: rtl/fifo_pkg.sv
// Shared helpers for the memory FIFO: parameter legality checks used at elaboration.
package fifo_pkg;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   function automatic bit params_ok(input int depth, input int addr_width,
                                    input int aempty_thresh, input int afull_thresh);
      return (depth >= 2) && (depth == (1 << addr_width)) && (clog2(depth) == addr_width)
          && (aempty_thresh >= 0) && (aempty_thresh < afull_thresh)
          && (afull_thresh <= depth);
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer; one extra MSB distinguishes full from empty.
module fifo_ptr #(
   parameter int ADDR_WIDTH = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inc,
   output logic [ADDR_WIDTH:0] ptr
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + (ADDR_WIDTH + 1)'(1);
      end
   end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// Synchronous first-word-fall-through FIFO: storage, pointer pair, status decode and
// sticky error flags.
module mem_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int DEPTH         = 8,
   parameter int ADDR_WIDTH    = 3,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic                  rd,
   input  logic [DATA_WIDTH-1:0] datain,
   output logic [DATA_WIDTH-1:0] dataout,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   if (!params_ok(DEPTH, ADDR_WIDTH, AEMPTY_THRESH, AFULL_THRESH)) begin : g_bad_params
      $error("mem_fifo_ctrl: illegal DEPTH/ADDR_WIDTH/threshold combination");
   end

   localparam logic [ADDR_WIDTH:0] AF_LVL = AFULL_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AE_LVL = AEMPTY_THRESH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [ADDR_WIDTH:0]   wrptr;
   logic [ADDR_WIDTH:0]   rdptr;
   logic                  rd_ok;
   logic                  wr_ok;

   fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wrptr (
      .clk   (clk),
      .reset (reset),
      .inc   (wr_ok),
      .ptr   (wrptr)
   );

   fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rdptr (
      .clk   (clk),
      .reset (reset),
      .inc   (rd_ok),
      .ptr   (rdptr)
   );

   always_comb begin
      empty        = (wrptr == rdptr);
      full         = (wrptr[ADDR_WIDTH] != rdptr[ADDR_WIDTH])
                  && (wrptr[ADDR_WIDTH-1:0] == rdptr[ADDR_WIDTH-1:0]);
      count        = wrptr - rdptr;
      almost_full  = (count >= AF_LVL);
      almost_empty = (count <= AE_LVL);
      rd_ok        = rd && !empty;
      // A write into a full FIFO is fine when the head slot is freed on the same edge.
      wr_ok        = wr && (!full || rd_ok);
   end

   // Storage is deliberately unreset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wrptr[ADDR_WIDTH-1:0]] <= datain;
      end
   end

   assign dataout = mem[rdptr[ADDR_WIDTH-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (wr && !wr_ok) || (overflow && !err_clr);
         underflow <= (rd && !rd_ok) || (underflow && !err_clr);
      end
   end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl: directed vector table, wrap/reset sequences
// and a random run, all scored against a queue model.
module tb_mem_fifo_ctrl;

   localparam int DW    = 64;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk;
   logic          reset;
   logic          wr;
   logic          rd;
   logic [DW-1:0] datain;
   logic [DW-1:0] dataout;
   logic          empty;
   logic          full;
   logic          almost_empty;
   logic          almost_full;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;
   logic          err_clr;

   mem_fifo_ctrl #(
      .DATA_WIDTH    (DW),
      .DEPTH         (DEPTH),
      .ADDR_WIDTH    (AW),
      .AFULL_THRESH  (DEPTH - 2),
      .AEMPTY_THRESH (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr           (wr),
      .rd           (rd),
      .datain       (datain),
      .dataout      (dataout),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .err_clr      (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          w;
      logic          r;
      logic          c;
      logic [DW-1:0] d;
      logic          has_dout;
      logic [DW-1:0] dout;
      int            cnt;
      logic          ovf;
      logic          unf;
   } vec_t;

   vec_t          tbl[$];
   logic [DW-1:0] mq[$];
   logic          m_ovf;
   logic          m_unf;
   int            n_cmp;
   int            n_bad;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      int sz;
      sz = mq.size();
      chk("count", DW'(count), DW'(sz));
      chk("empty", DW'(empty), DW'(sz == 0));
      chk("full", DW'(full), DW'(sz == DEPTH));
      chk("almost_full", DW'(almost_full), DW'(sz >= DEPTH - 2));
      chk("almost_empty", DW'(almost_empty), DW'(sz <= 2));
      chk("overflow", DW'(overflow), DW'(m_ovf));
      chk("underflow", DW'(underflow), DW'(m_unf));
      if (sz != 0) chk("head", dataout, mq[0]);
   endtask

   // Drive one cycle from a falling edge; returns at the next falling edge.
   task automatic step(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
      bit rok;
      bit wok;
      wr = w; rd = r; err_clr = c; datain = d;
      #1;
      rok = r && (mq.size() != 0);
      wok = w && ((mq.size() < DEPTH) || rok);
      if (rok) begin
         chk("rd_data", dataout, mq[0]);
         void'(mq.pop_front());
      end
      if (wok) mq.push_back(d);
      m_ovf = (w && !wok) || (m_ovf && !c);
      m_unf = (r && !rok) || (m_unf && !c);
      @(posedge clk);
      #1;
      check_state();
      @(negedge clk);
      wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
   endtask

   function automatic void add(input logic w, input logic r, input logic c,
                               input logic [DW-1:0] d, input logic has_dout,
                               input logic [DW-1:0] dout, input int cnt,
                               input logic ovf, input logic unf);
      vec_t v;
      v.w = w; v.r = r; v.c = c; v.d = d; v.has_dout = has_dout; v.dout = dout;
      v.cnt = cnt; v.ovf = ovf; v.unf = unf;
      tbl.push_back(v);
   endfunction

   initial begin
      n_cmp = 0; n_bad = 0; m_ovf = 1'b0; m_unf = 1'b0;
      wr = 1'b0; rd = 1'b0; err_clr = 1'b0; datain = '0;

      // fill to full, overflow, rd&wr while full, drain, underflow, rd&wr while empty, clear
      for (int i = 1; i <= 8; i++) add(1, 0, 0, DW'(i * 'h11), 0, '0, i, 0, 0);
      add(1, 0, 0, 'h99, 0, '0, 8, 1, 0);
      add(1, 1, 0, 'hAA, 1, 'h11, 8, 1, 0);
      for (int i = 2; i <= 8; i++) add(0, 1, 0, '0, 1, DW'(i * 'h11), 9 - i, 1, 0);
      add(0, 1, 0, '0, 1, 'hAA, 0, 1, 0);
      add(0, 1, 0, '0, 0, '0, 0, 1, 1);
      add(1, 1, 0, 'h55, 0, '0, 1, 1, 1);
      add(0, 0, 1, '0, 0, '0, 1, 0, 0);

      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check_state();
      chk("rst_count", DW'(count), 0);
      chk("rst_ae", DW'(almost_empty), 1);
      @(negedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].has_dout) chk("tbl_dout", dataout, tbl[i].dout);
         step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
         chk("tbl_count", DW'(count), DW'(tbl[i].cnt));
         chk("tbl_full", DW'(full), DW'(tbl[i].cnt == 8));
         chk("tbl_empty", DW'(empty), DW'(tbl[i].cnt == 0));
         chk("tbl_af", DW'(almost_full), DW'(tbl[i].cnt >= 6));
         chk("tbl_ae", DW'(almost_empty), DW'(tbl[i].cnt <= 2));
         chk("tbl_ovf", DW'(overflow), DW'(tbl[i].ovf));
         chk("tbl_unf", DW'(underflow), DW'(tbl[i].unf));
      end
      chk("tbl_head55", dataout, 'h55);
      step(0, 1, 0, '0);

      // wrap-around: pointers pass the top of memory twice
      for (int b = 0; b < 6; b++) begin
         for (int k = 0; k < 3; k++) step(1, 0, 0, DW'(b * 16 + k + 1));
         for (int k = 0; k < 3; k++) begin
            chk("wrap_dout", dataout, DW'(b * 16 + k + 1));
            step(0, 1, 0, '0);
         end
         chk("wrap_empty", DW'(empty), 1);
      end

      // asynchronous reset mid-operation with a flag set
      step(0, 1, 0, '0);
      for (int k = 0; k < 5; k++) step(1, 0, 0, DW'('hC0 + k));
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_empty", DW'(empty), 1);
      chk("mid_rst_count", DW'(count), 0);
      chk("mid_rst_unf", DW'(underflow), 0);
      chk("mid_rst_ovf", DW'(overflow), 0);
      mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      step(1, 0, 0, 'h77);
      chk("post_rst_dout", dataout, 'h77);
      step(0, 1, 0, '0);

      // random traffic with shifting read/write bias to reach both boundaries
      for (int i = 0; i < 10000; i++) begin
         int pw;
         int pr;
         pw = ((i / 500) % 2 == 0) ? 70 : 30;
         pr = 100 - pw;
         step($urandom_range(99) < pw, $urandom_range(99) < pr, $urandom_range(49) == 0,
              {$urandom, $urandom});
         if (n_bad > 50) break;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_fifo_ctrl.md
# mem_fifo_ctrl

Parametrised synchronous FIFO with integrated memory and controller. It buffers DATA_WIDTH-bit words between a producer and a consumer in a single clock domain, and is the drop-in successor to the current fixed 8×64 buffer used in the AXI data paths. Beyond plain buffering, it adds:
- full flag and occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- safe handling of simultaneous read and write at the full and empty boundaries.

## Interface
- DATA_WIDTH, 64, word width in bits
- DEPTH, 8, number of entries; power of two, ≥ 2
- ADDR_WIDTH, 3, log2(DEPTH); must match DEPTH
- AFULL_THRESH, DEPTH-2, almost_full asserts when count ≥ this
- AEMPTY_THRESH, 2, almost_empty asserts when count ≤ this

- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears all controller state
- wr  in  1  write request; accepted when !full, or when full with an accepted read in the same cycle
- rd  in  1  read request; accepted when !empty
- datain  in  DATA_WIDTH  write data, sampled on an accepted write
- dataout  out  DATA_WIDTH  head-of-FIFO word (first-word-fall-through)
- empty  out  1  no valid entries
- full  out  1  DEPTH valid entries
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- almost_full  out  1  count ≥ AFULL_THRESH
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; set by a rejected write
- underflow  out  1  sticky; set by a rejected read
- err_clr  in  1  synchronous clear of overflow and underflow

## Operation
- Pointers: wrptr and rdptr, each ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits index memory.
  - empty = (wrptr == rdptr).
  - full = MSBs differ and low bits are equal.
  - count = wrptr − rdptr, modulo 2^(ADDR_WIDTH+1).
- Acceptance:
  - rd_ok = rd & !empty.
  - wr_ok = wr & (!full | rd_ok).
- On wr_ok: mem[wrptr low bits] <= datain; wrptr increments.
- On rd_ok: rdptr increments.
- Wrap-around: the low bits roll over DEPTH-1 → 0 naturally; the MSB toggles.
- Simultaneous rd & wr:
  - when empty: the write is accepted, the read is rejected (underflow set), and count becomes 1;
  - when full: both are accepted, count stays DEPTH, and the written word lands in the slot being freed.
  - Otherwise both are accepted and count is unchanged.
- Error flags:
  - overflow <= 1 when wr & !wr_ok.
  - underflow <= 1 when rd & !rd_ok.
  - err_clr clears both flags; if set and clear occur in the same cycle, set wins.
- dataout = mem[rdptr low bits], combinational from the registered pointer. It is valid only while !empty; its value while empty is don't-care.
- Memory is not reset (it maps to RAM). Only pointers and error flags reset.
- Reset values: wrptr = rdptr = 0, empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0.
- Reset asserted mid-operation discards all contents immediately and asynchronously; the FIFO is empty from the first edge after deassertion.

## Timing
- Write-to-read latency: a word written on edge N is visible on dataout, with empty = 0, after edge N.
  - It can be read on edge N+1.
- Read: the consumer samples dataout in the cycle rd is high; the next word appears after that edge.
- empty, full, count, almost_empty and almost_full are combinational decodes of the registered pointers. They update one edge after the causing request, with no extra pipeline stage.
- overflow and underflow assert after the edge on which the rejected request is sampled.
- There are no combinational paths from wr, rd or datain to any output.

## Structure
- Shared package fifo_pkg:
  - function clog2 for parameter checking;
  - elaboration assertion that DEPTH == 2**ADDR_WIDTH;
  - threshold range checks: 0 ≤ AEMPTY_THRESH < AFULL_THRESH ≤ DEPTH.
- Sub-module fifo_ptr, instantiated twice (write and read):
  - inputs: clk, reset, inc;
  - output: ADDR_WIDTH+1-bit pointer.
- The storage array and flag logic are in the top module.

## Test plan
- Reset, then write 0x11..0x88 to DEPTH = 8 with no reads:
  - full = 1 and count = 8 after the 8th edge;
  - almost_full = 1 from count = 6;
  - then read all 8 and check dataout order 0x11..0x88, with empty = 1 at the end.
- Wrap-around: 3 writes / 3 reads, repeated 6 times (pointers pass 7 → 0 twice) → data order preserved, empty = 1 between batches.
- Boundaries while full: wr alone → overflow = 1, count stays 8, contents unchanged. Then rd & wr with 0xAA → count stays 8, and 0xAA emerges last after draining.
- Boundaries while empty: rd alone → underflow = 1. Then rd & wr with 0x55 → underflow stays 1, count = 1, dataout = 0x55. err_clr → both flags 0.
- Reset mid-operation: write 5 words, then assert reset between edges → empty = 1, count = 0 and flags cleared immediately. After release, write 0x77 → dataout = 0x77 after the next edge.
- Random rd/wr for 10,000 cycles checked against a queue model → dataout, count, flags and errors all match every cycle.
